// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/memory slice: reset defaults and the
// data-access width decoding used by the memory unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_width_e;

    // Word strobe wins over halfword; neither means a single byte.
    function automatic access_width_e decode_width(input logic wrd, input logic hwrd);
        if (wrd)
            return WORD;
        else if (hwrd)
            return HALF;
        return BYTE;
    endfunction

    function automatic logic [2:0] width_bytes(input access_width_e w);
        case (w)
            WORD:    return 3'd4;
            HALF:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/fetch_mmu_if.sv
// Data-memory bus between the core's load/store stage and fetch_mmu.
interface fetch_mmu_if;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_write;
    logic        dmem_read;
    logic        dmem_rdu;
    logic        dmem_hwrd;
    logic        dmem_wrd;
    logic        dmem_drdy;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_addr, dmem_wdata, dmem_write, dmem_read,
               dmem_rdu, dmem_hwrd, dmem_wrd,
        input  dmem_drdy, dmem_rdata
    );

    modport slave (
        input  dmem_addr, dmem_wdata, dmem_write, dmem_read,
               dmem_rdu, dmem_hwrd, dmem_wrd,
        output dmem_drdy, dmem_rdata
    );
endinterface

// File: rtl/mem_unit.sv
// Byte-addressed instruction and data memories with combinational reads,
// little-endian multi-byte access and address wrap-around.
module mem_unit
    import fetch_pkg::*;
#(
    parameter int IMEM_BYTES = 4096,
    parameter int DMEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       imem_addr,
    output logic [31:0]       imem_rdata,
    fetch_mmu_if.slave        dmem
);

    localparam int IAW = $clog2(IMEM_BYTES);
    localparam int DAW = $clog2(DMEM_BYTES);

    logic [7:0] icache_l1 [IMEM_BYTES];
    logic [7:0] dcache_l1 [DMEM_BYTES];

    logic [IAW-1:0] ibase;
    logic [DAW-1:0] dbase;
    logic [31:0]    draw;
    logic [31:0]    drdata;
    logic [2:0]     wr_bytes;
    access_width_e  width;

    wire unused_addr_hi = ^{imem_addr[31:IAW], dmem.dmem_addr[31:DAW]};

    assign ibase    = imem_addr[IAW-1:0];
    assign dbase    = dmem.dmem_addr[DAW-1:0];
    assign width    = decode_width(dmem.dmem_wrd, dmem.dmem_hwrd);
    assign wr_bytes = width_bytes(width);

    // Byte indices are kept at memory-address width so they wrap naturally.
    always_comb begin
        imem_rdata = '0;
        draw       = '0;
        for (int k = 0; k < 4; k++) begin
            imem_rdata[8*k +: 8] = icache_l1[ibase + IAW'(k)];
            draw[8*k +: 8]       = dcache_l1[dbase + DAW'(k)];
        end
    end

    always_comb begin
        drdata = '0;
        case (width)
            WORD:    drdata = draw;
            HALF:    drdata = {{16{~dmem.dmem_rdu & draw[15]}}, draw[15:0]};
            default: drdata = {{24{~dmem.dmem_rdu & draw[7]}}, draw[7:0]};
        endcase
        if (!dmem.dmem_read)
            drdata = '0;
    end

    assign dmem.dmem_rdata = drdata;
    assign dmem.dmem_drdy  = dmem.dmem_read | dmem.dmem_write;

    // Reads above sample the array before this edge updates it.
    always_ff @(posedge clk) begin
        if (!rst && dmem.dmem_write) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < wr_bytes)
                    dcache_l1[dbase + DAW'(k)] <= dmem.dmem_wdata[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/fetch_mmu.sv
// Instruction fetch front end: next-PC, bubble insertion and the decode
// instruction register. FETCH_IMEM_WAIT_EN adds one wait cycle per new pc.
module fetch_mmu
    import fetch_pkg::*;
#(
    parameter int          IMEM_BYTES = 4096,
    parameter int          DMEM_BYTES = 4096,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] newpc,
    output logic [31:0] fetch_dec_instr,
    fetch_mmu_if.slave  dmem
);

    logic [31:0] imem_rdata;
    logic        imem_drdy;

    mem_unit #(
        .IMEM_BYTES (IMEM_BYTES),
        .DMEM_BYTES (DMEM_BYTES)
    ) u_mem (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (pc),
        .imem_rdata (imem_rdata),
        .dmem       (dmem)
    );

`ifdef FETCH_IMEM_WAIT_EN
    logic [31:0] prev_pc;
    logic        prev_valid;

    // The instruction is ready only once the same pc has been held for a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
        end else begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
        end
    end

    assign imem_drdy = prev_valid && (pc == prev_pc);
`else
    assign imem_drdy = 1'b1;
`endif

    always_comb begin
        newpc = pc;
        if (rst)
            newpc = RESET_PC;
        else if (imem_drdy)
            newpc = pc + 32'd4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_dec_instr <= NOP_INSTR;
        else
            fetch_dec_instr <= imem_drdy ? imem_rdata : NOP_INSTR;
    end

endmodule

// File: tb/tb_fetch_mmu.sv
// Self-checking bench for fetch_mmu: directed vector table, multi-cycle
// sequences and randomized traffic against a byte-array reference model.
module tb_fetch_mmu;
    import fetch_pkg::*;

    localparam int          IMEM = 4096;
    localparam int          DMEM = 4096;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] newpc;
    logic [31:0] fetch_dec_instr;

    fetch_mmu_if dmem_bus ();

    fetch_mmu #(
        .IMEM_BYTES (IMEM),
        .DMEM_BYTES (DMEM)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .newpc           (newpc),
        .fetch_dec_instr (fetch_dec_instr),
        .dmem            (dmem_bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic        read;
        logic        rdu;
        logic        hwrd;
        logic        wrd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } dvec_t;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] imem_m [IMEM];
    logic [7:0] dmem_m [DMEM];
    logic        m_seen;
    logic [31:0] m_last_pc;

`ifdef FETCH_IMEM_WAIT_EN
    localparam int NSEQ = 6;
    logic [31:0] seq_fetch [NSEQ] = '{NOP, 32'h0000_0013, NOP, 32'h0010_0093, NOP, 32'h0020_0113};
    logic [31:0] seq_np    [NSEQ] = '{32'd0, 32'd4, 32'd4, 32'd8, 32'd8, 32'd12};
    localparam int REPEAT_PC = 2;
`else
    localparam int NSEQ = 3;
    logic [31:0] seq_fetch [NSEQ] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};
    logic [31:0] seq_np    [NSEQ] = '{32'd4, 32'd8, 32'd12};
    localparam int REPEAT_PC = 1;
`endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] imemWord(input logic [31:0] p);
        int a;
        a = int'(p % IMEM);
        return {imem_m[(a+3)%IMEM], imem_m[(a+2)%IMEM], imem_m[(a+1)%IMEM], imem_m[a]};
    endfunction

    function automatic logic [31:0] modelRead(input dvec_t v);
        int a;
        int n;
        logic [31:0] val;
        if (!v.read) return 32'd0;
        a   = int'(v.addr % DMEM);
        n   = v.wrd ? 4 : (v.hwrd ? 2 : 1);
        val = 32'd0;
        for (int k = 0; k < n; k++) val = val + (32'(dmem_m[(a+k)%DMEM]) << (8*k));
        if (!v.rdu && n == 2 && val >= 32'h8000) val = val + 32'hFFFF_0000;
        if (!v.rdu && n == 1 && val >= 32'h80)   val = val + 32'hFFFF_FF00;
        return val;
    endfunction

    task automatic modelWrite(input dvec_t v);
        int a;
        int n;
        a = int'(v.addr % DMEM);
        n = v.wrd ? 4 : (v.hwrd ? 2 : 1);
        for (int k = 0; k < n; k++) dmem_m[(a+k)%DMEM] = v.wdata[8*k +: 8];
    endtask

    task automatic preloadI(input int idx, input logic [7:0] b);
        imem_m[idx] = b;
        dut.u_mem.icache_l1[idx] = b;
    endtask

    task automatic preloadWord(input int idx, input logic [31:0] w);
        for (int k = 0; k < 4; k++) preloadI(idx + k, w[8*k +: 8]);
    endtask

    task automatic applyStimulus(input dvec_t v);
        dmem_bus.dmem_write = v.write;
        dmem_bus.dmem_read  = v.read;
        dmem_bus.dmem_rdu   = v.rdu;
        dmem_bus.dmem_hwrd  = v.hwrd;
        dmem_bus.dmem_wrd   = v.wrd;
        dmem_bus.dmem_addr  = v.addr;
        dmem_bus.dmem_wdata = v.wdata;
    endtask

    // One fetch cycle: present p, check newpc mid-cycle, check the register after the edge.
    task automatic stepFetch(input logic [31:0] p, output logic [31:0] seen_np, output logic [31:0] seen_f);
        logic        ready;
        logic [31:0] exp_np;
        logic [31:0] exp_f;
        pc = p;
`ifdef FETCH_IMEM_WAIT_EN
        ready = m_seen && (p == m_last_pc);
`else
        ready = 1'b1;
`endif
        exp_np = ready ? p + 32'd4 : p;
        exp_f  = ready ? imemWord(p) : NOP;
        @(negedge clk);
        seen_np = newpc;
        checkOutput("newpc", newpc, exp_np);
        @(posedge clk);
        #1;
        seen_f = fetch_dec_instr;
        checkOutput("fetch", fetch_dec_instr, exp_f);
        m_seen    = 1'b1;
        m_last_pc = p;
    endtask

    // Data cycle: inputs set just after an edge, read checked mid-cycle, write lands on the next edge.
    task automatic dataCycle(input dvec_t v, input logic [31:0] exp_rd, input string name);
        applyStimulus(v);
        @(negedge clk);
        checkOutput({name, "_rdata"}, dmem_bus.dmem_rdata, exp_rd);
        checkOutput({name, "_drdy"}, {31'd0, dmem_bus.dmem_drdy}, {31'd0, v.read | v.write});
        @(posedge clk);
        #1;
        if (v.write && !rst) modelWrite(v);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        dvec_t       dtab [19];
        dvec_t       v;
        dvec_t       idle;
        logic [31:0] p;
        logic [31:0] np;
        logic [31:0] f;

        idle = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0};
        dtab[0]  = '{1, 0, 0, 0, 1, 32'h10,   32'hDEADBEEF, 32'h0};
        dtab[1]  = '{0, 1, 0, 0, 0, 32'h10,   32'h0,        32'hFFFFFFEF};
        dtab[2]  = '{0, 1, 1, 0, 0, 32'h10,   32'h0,        32'h000000EF};
        dtab[3]  = '{0, 1, 0, 1, 0, 32'h12,   32'h0,        32'hFFFFDEAD};
        dtab[4]  = '{0, 1, 0, 0, 1, 32'h10,   32'h0,        32'hDEADBEEF};
        dtab[5]  = '{0, 1, 1, 1, 0, 32'h10,   32'h0,        32'h0000BEEF};
        dtab[6]  = '{0, 1, 0, 1, 1, 32'h10,   32'h0,        32'hDEADBEEF};
        dtab[7]  = '{0, 0, 0, 0, 1, 32'h10,   32'h0,        32'h0};
        dtab[8]  = '{1, 1, 0, 0, 1, 32'h10,   32'h01020304, 32'hDEADBEEF};
        dtab[9]  = '{0, 1, 0, 0, 1, 32'h10,   32'h0,        32'h01020304};
        dtab[10] = '{1, 0, 0, 1, 0, 32'h11,   32'h0000AA55, 32'h0};
        dtab[11] = '{0, 1, 0, 0, 1, 32'h10,   32'h0,        32'h01AA5504};
        dtab[12] = '{1, 0, 0, 0, 1, 32'hFFE,  32'hCAFEF00D, 32'h0};
        dtab[13] = '{0, 1, 0, 0, 1, 32'hFFE,  32'h0,        32'hCAFEF00D};
        dtab[14] = '{0, 1, 1, 0, 0, 32'h0,    32'h0,        32'h000000FE};
        dtab[15] = '{0, 1, 0, 0, 0, 32'h1,    32'h0,        32'hFFFFFFCA};
        dtab[16] = '{1, 0, 0, 0, 0, 32'h13,   32'h12345680, 32'h0};
        dtab[17] = '{0, 1, 0, 1, 0, 32'h12,   32'h0,        32'hFFFF80AA};
        dtab[18] = '{0, 1, 0, 0, 1, 32'h1010, 32'h0,        32'h80AA5504};

        rst = 1'b1;
        pc  = 32'h0000_0123;
        applyStimulus(idle);
        m_seen    = 1'b0;
        m_last_pc = '0;

        for (int i = 0; i < IMEM; i++) preloadI(i, 8'($urandom));
        for (int i = 0; i < DMEM; i++) begin
            dmem_m[i] = 8'($urandom);
            dut.u_mem.dcache_l1[i] = dmem_m[i];
        end
        preloadWord(0, 32'h0000_0013);
        preloadWord(4, 32'h0010_0093);
        preloadWord(8, 32'h0020_0113);
        preloadI(32'h20, 8'h78); preloadI(32'h21, 8'h56);
        preloadI(32'h22, 8'h34); preloadI(32'h23, 8'h12);
        preloadWord(32'hFFC, 32'h4433_2211);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_fetch", fetch_dec_instr, NOP);
        checkOutput("reset_newpc", newpc, 32'd0);
        rst = 1'b0;

        // Program start with pc fed back from newpc.
        p = 32'd0;
        for (int i = 0; i < NSEQ; i++) begin
            stepFetch(p, np, f);
            checkOutput("seq_fetch", f, seq_fetch[i]);
            checkOutput("seq_newpc", np, seq_np[i]);
            p = np;
        end

        for (int r = 0; r < REPEAT_PC; r++) stepFetch(32'h20, np, f);
        checkOutput("le_fetch", f, 32'h1234_5678);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_fetch", fetch_dec_instr, NOP);
        checkOutput("async_rst_newpc", newpc, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_seen = 1'b0;

        for (int r = 0; r < REPEAT_PC; r++) stepFetch(32'hFFFF_FFFC, np, f);
        checkOutput("wrap_newpc", np, 32'd0);
        checkOutput("wrap_fetch", f, 32'h4433_2211);

        for (int i = 0; i < 19; i++) dataCycle(dtab[i], dtab[i].exp_rdata, $sformatf("vec%0d", i));
        applyStimulus(idle);

        // Writes are blocked during reset; memory survives reset.
        rst = 1'b1;
        v = '{1, 0, 0, 0, 1, 32'h40, 32'h11223344, 32'h0};
        dataCycle(v, 32'd0, "rst_write");
        rst    = 1'b0;
        m_seen = 1'b0;
        v = '{0, 1, 0, 0, 1, 32'h40, 32'h0, 32'h0};
        dataCycle(v, modelRead(v), "rst_suppress");
        v = '{0, 1, 0, 0, 1, 32'h10, 32'h0, 32'h0};
        dataCycle(v, 32'h80AA5504, "rst_keep");
        applyStimulus(idle);

        for (int i = 0; i < 40; i++) begin
            p = $urandom;
            for (int r = 0; r < REPEAT_PC; r++) stepFetch(p, np, f);
        end

        for (int i = 0; i < 200; i++) begin
            v.write = 1'($urandom);
            v.read  = 1'($urandom);
            v.rdu   = 1'($urandom);
            v.hwrd  = 1'($urandom);
            v.wrd   = 1'($urandom);
            v.addr  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            v.wdata = $urandom;
            v.exp_rdata = 32'd0;
            dataCycle(v, modelRead(v), "rand_data");
        end
        applyStimulus(idle);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
